// File: rtl/clock_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clock_disp_pkg
// Brief   : Shared constants for the multiplexed HH:MM:SS seven-segment
//           display: digit count, digit slot indices and glyph patterns.
// Revision: 1.0 - initial release
// ============================================================================
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    // Digit slot indices, left to right on the display
    localparam logic [2:0] HR_T  = 3'd0;
    localparam logic [2:0] HR_U  = 3'd1;
    localparam logic [2:0] MIN_T = 3'd2;
    localparam logic [2:0] MIN_U = 3'd3;
    localparam logic [2:0] SEC_T = 3'd4;
    localparam logic [2:0] SEC_U = 3'd5;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage : clock_disp_pkg
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module  : bcd_to_seg7
// Brief   : Combinational BCD to seven-segment decoder (active-high).
//           Non-decimal codes A-F show a dash so bad input is visible.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Glyph lookup; anything outside 0-9 is flagged with a dash
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/clock_display_mux.sv
`default_nettype none
// ============================================================================
// Module  : clock_display_mux
// Brief   : Drives a 6-digit multiplexed seven-segment display from HH:MM:SS
//           BCD digits. Each slot starts with one blank cycle (anti-ghost),
//           digits are snapshotted once per frame, the hours tens digit may
//           be leading-zero blanked and the colon DPs blink.
// Revision: 1.0 - initial release
// ============================================================================
module clock_display_mux
    import clock_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 4,
    parameter int BLINK_FRAMES   = 500,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ms_hr,
    input  logic [3:0] ls_hr,
    input  logic [3:0] ms_min,
    input  logic [3:0] ls_min,
    input  logic [3:0] ms_sec,
    input  logic [3:0] ls_sec,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_start
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    // A single-frame blink period still needs a 1-bit counter to exist
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic c_SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic c_AN_INV  = (AN_ACTIVE_LOW != 0);

    // Sequencing state
    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_idx;
    logic [FRM_W-1:0] r_frm_cnt;
    logic             r_blink;

    // Per-frame snapshot of the input digits and the blanking request
    logic [3:0]       r_snap [NUM_DIGITS];
    logic             r_blank_lz;

    // Output registers hold the pin-polarity values
    logic [6:0]       r_seg;
    logic             r_dp;
    logic [5:0]       r_an;
    logic             r_frame_start;

    logic             w_div_last;
    logic             w_idx_last;
    logic             w_frm_last;
    logic             w_slot_blank;
    logic             w_snap_en;
    logic [3:0]       w_digit;
    logic [6:0]       w_glyph;
    logic             w_lz_blank;
    logic             w_colon;
    logic [6:0]       w_seg_nxt;
    logic             w_dp_nxt;
    logic [5:0]       w_an_nxt;
    logic             w_fs_nxt;

    assign w_div_last   = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
    assign w_idx_last   = (r_idx == SEC_U);
    assign w_frm_last   = (r_frm_cnt == FRM_W'(BLINK_FRAMES - 1));
    assign w_slot_blank = (r_div_cnt == '0);
    assign w_snap_en    = w_slot_blank && (r_idx == HR_T);

    // Counter chain: slot cycles -> digit index -> frames -> blink phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
            r_frm_cnt <= '0;
            r_blink   <= 1'b0;
        end else if (w_div_last) begin
            r_div_cnt <= '0;
            if (w_idx_last) begin
                r_idx <= '0;
                if (w_frm_last) begin
                    r_frm_cnt <= '0;
                    r_blink   <= ~r_blink;
                end else begin
                    r_frm_cnt <= r_frm_cnt + FRM_W'(1);
                end
            end else begin
                r_idx <= r_idx + 3'd1;
            end
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Latch all digits at the start of each frame so a frame never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_snap[i] <= '0;
            end
            r_blank_lz <= 1'b0;
        end else if (w_snap_en) begin
            r_snap[HR_T]  <= ms_hr;
            r_snap[HR_U]  <= ls_hr;
            r_snap[MIN_T] <= ms_min;
            r_snap[MIN_U] <= ls_min;
            r_snap[SEC_T] <= ms_sec;
            r_snap[SEC_U] <= ls_sec;
            r_blank_lz    <= blank_lz;
        end
    end

    // Select the snapshot digit for the current slot
    always_comb begin
        w_digit = r_snap[HR_T];
        case (r_idx)
            HR_T:    w_digit = r_snap[HR_T];
            HR_U:    w_digit = r_snap[HR_U];
            MIN_T:   w_digit = r_snap[MIN_T];
            MIN_U:   w_digit = r_snap[MIN_U];
            SEC_T:   w_digit = r_snap[SEC_T];
            SEC_U:   w_digit = r_snap[SEC_U];
            default: w_digit = r_snap[HR_T];
        endcase
    end

    bcd_to_seg7 u_bcd_to_seg7 (
        .i_bcd (w_digit),
        .o_seg (w_glyph)
    );

    // Only the hours tens digit may be suppressed when it reads zero
    assign w_lz_blank = (r_idx == HR_T) && r_blank_lz && (r_snap[HR_T] == 4'd0);
    assign w_colon    = (r_idx == HR_U) || (r_idx == MIN_U);

    // Next active-high output values for the current state
    always_comb begin
        w_seg_nxt = SEG_OFF;
        w_dp_nxt  = 1'b0;
        w_an_nxt  = '0;
        w_fs_nxt  = 1'b0;
        if (w_slot_blank) begin
            w_fs_nxt = (r_idx == HR_T);
        end else begin
            w_an_nxt  = 6'b000001 << r_idx;
            w_seg_nxt = w_lz_blank ? SEG_OFF : w_glyph;
            w_dp_nxt  = r_blink && w_colon && !w_lz_blank;
        end
    end

    // Registered outputs with pin polarity folded in, reset included
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg         <= {7{c_SEG_INV}};
            r_dp          <= c_SEG_INV;
            r_an          <= {6{c_AN_INV}};
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_seg_nxt ^ {7{c_SEG_INV}};
            r_dp          <= w_dp_nxt ^ c_SEG_INV;
            r_an          <= w_an_nxt ^ {6{c_AN_INV}};
            r_frame_start <= w_fs_nxt;
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;
    assign frame_start = r_frame_start;

endmodule : clock_display_mux
`default_nettype wire

// File: tb/tb_clock_display_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_display_mux
// Brief   : Self-checking bench for clock_display_mux. A cycle-count based
//           reference model predicts every output cycle; an inverted-polarity
//           instance runs alongside on the same stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_clock_display_mux;

    localparam int RD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = 6 * RD;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec;
    logic       blank_lz;
    logic [6:0] seg, seg_n;
    logic       dp, dp_n;
    logic [5:0] an, an_n;
    logic       frame_start, frame_start_n;

    int checks   = 0;
    int failures = 0;

    // Reference model state: cycles processed since reset release
    int         m_t;
    logic [3:0] m_snap [6];
    logic       m_blz;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;

    clock_display_mux #(
        .REFRESH_DIV    (RD),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (0),
        .AN_ACTIVE_LOW  (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ms_hr       (ms_hr),
        .ls_hr       (ls_hr),
        .ms_min      (ms_min),
        .ls_min      (ls_min),
        .ms_sec      (ms_sec),
        .ls_sec      (ls_sec),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    clock_display_mux #(
        .REFRESH_DIV    (RD),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut_n (
        .clk         (clk),
        .rst         (rst),
        .ms_hr       (ms_hr),
        .ls_hr       (ls_hr),
        .ms_min      (ms_min),
        .ls_min      (ls_min),
        .ms_sec      (ms_sec),
        .ls_sec      (ls_sec),
        .blank_lz    (blank_lz),
        .seg         (seg_n),
        .dp          (dp_n),
        .an          (an_n),
        .frame_start (frame_start_n)
    );

    always #5 clk = ~clk;

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                              input logic [3:0] d, input logic [3:0] e, input logic [3:0] f);
        ms_hr = a; ls_hr = b; ms_min = c; ls_min = d; ms_sec = e; ls_sec = f;
    endtask

    // Predict the output for the upcoming edge, then advance one clock
    task automatic tick();
        int p, slot, sub, frame;
        logic blink;
        if (rst) begin
            e_an = '0; e_seg = '0; e_dp = 1'b0; e_fs = 1'b0;
            m_t  = 0;
        end else begin
            p     = m_t % FRAME;
            slot  = p / RD;
            sub   = p % RD;
            frame = m_t / FRAME;
            blink = ((frame / BF) % 2) == 1;
            if (p == 0) begin
                m_snap = '{ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec};
                m_blz  = blank_lz;
            end
            if (sub == 0) begin
                e_an = '0; e_seg = '0; e_dp = 1'b0; e_fs = (slot == 0);
            end else begin
                e_an  = 6'(1 << slot);
                e_seg = (slot == 0 && m_blz && m_snap[0] == 4'd0) ? 7'h00 : GLYPH[m_snap[slot]];
                e_dp  = blink && (slot == 1 || slot == 3);
                e_fs  = 1'b0;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        blank_lz = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({an, seg, dp, frame_start} !== 15'd0) begin
                failures++;
                $display("FAIL reset_hi an=%h seg=%h dp=%b fs=%b want all 0", an, seg, dp, frame_start);
            end
            checks++;
            if ({an_n, seg_n, dp_n, frame_start_n} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL reset_lo an=%h seg=%h dp=%b fs=%b want an=3f seg=7f dp=1 fs=0",
                         an_n, seg_n, dp_n, frame_start_n);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (frame_start !== 1'b1 || an !== 6'd0) begin
            failures++;
            $display("FAIL release_fs fs=%b an=%h want fs=1 an=00", frame_start, an);
        end
        tick();
        checks++;
        if (an !== 6'b000001 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL release_an an=%h fs=%b want an=01 fs=0", an, frame_start);
        end
    endtask

    task automatic test_hold();
        int fs_seen;
        fs_seen = 0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (frame_start === 1'b1) fs_seen++;
            checks++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                failures++;
                $display("FAIL hold t=%0d an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                         m_t, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
            end
        end
        checks++;
        if (fs_seen != 3) begin
            failures++;
            $display("FAIL hold_fs_count got=%0d want=3", fs_seen);
        end
    endtask

    task automatic test_leading_zero();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin set_digits(4'd0, 4'd7, 4'd5, 4'd9, 4'd0, 4'd1); blank_lz = 1'b1; end
                1: begin set_digits(4'd0, 4'd7, 4'd5, 4'd9, 4'd0, 4'd1); blank_lz = 1'b0; end
                default: begin set_digits(4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0); blank_lz = 1'b1; end
            endcase
            for (int i = 0; i < 2 * FRAME; i++) begin
                tick();
                checks++;
                if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                    failures++;
                    $display("FAIL lz%0d t=%0d an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                             k, m_t, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_midframe_change();
        set_digits(4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd9);
        for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != 3 * RD + 2; i++) begin
            tick();
            checks++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                failures++;
                $display("FAIL mid_pre t=%0d an=%h seg=%h want an=%h seg=%h", m_t, an, seg, e_an, e_seg);
            end
        end
        set_digits(4'd1, 4'd8, 4'd0, 4'd1, 4'd3, 4'd7);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                failures++;
                $display("FAIL mid_post t=%0d an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                         m_t, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
            end
        end
    endtask

    task automatic test_invalid_bcd();
        set_digits(4'd1, 4'd2, 4'hF, 4'd4, 4'd5, 4'hC);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                failures++;
                $display("FAIL invalid t=%0d an=%h seg=%h want an=%h seg=%h", m_t, an, seg, e_an, e_seg);
            end
        end
    endtask

    task automatic test_blink();
        int dp_cycles;
        dp_cycles = 0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        for (int i = 0; i < 8 * FRAME; i++) begin
            tick();
            if (dp === 1'b1) dp_cycles++;
            checks++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                failures++;
                $display("FAIL blink t=%0d an=%h dp=%b want an=%h dp=%b", m_t, an, dp, e_an, e_dp);
            end
        end
        // Any 8 consecutive frames hold exactly 4 blink-on frames, 2 lit slots x 3 cycles each
        checks++;
        if (dp_cycles != 4 * 2 * (RD - 1)) begin
            failures++;
            $display("FAIL blink_count got=%0d want=%0d", dp_cycles, 4 * 2 * (RD - 1));
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (!((((m_t / FRAME) / BF) % 2) == 1 && (m_t % FRAME) == 4 * RD + 2) && guard < 8 * FRAME) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 8 * FRAME) begin
            failures++;
            $display("FAIL rst_mid_seek cycles=%0d limit=%0d", guard, 8 * FRAME);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({an, seg, dp, frame_start} !== 15'd0) begin
            failures++;
            $display("FAIL rst_mid an=%h seg=%h dp=%b fs=%b want all 0", an, seg, dp, frame_start);
        end
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                failures++;
                $display("FAIL rst_restart t=%0d an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                         m_t, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12 * FRAME; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                set_digits(4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                           4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                           4'($urandom_range(0, 5)), 4'($urandom_range(0, 15)));
                blank_lz = 1'($urandom_range(0, 1));
            end
            tick();
            checks++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                failures++;
                $display("FAIL rand t=%0d an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                         m_t, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
            end
            checks++;
            if ({an_n, seg_n, dp_n, frame_start_n} !== {~e_an, ~e_seg, ~e_dp, e_fs}) begin
                failures++;
                $display("FAIL rand_lo t=%0d an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                         m_t, an_n, seg_n, dp_n, frame_start_n, ~e_an, ~e_seg, ~e_dp, e_fs);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        blank_lz = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        m_t = 0;
        m_snap = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        m_blz = 1'b0;
        #1;
        test_reset();
        test_hold();
        test_leading_zero();
        test_midframe_change();
        test_invalid_bcd();
        test_blink();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_clock_display_mux
`default_nettype wire
